axis_out_serializer: RTL
========================

Name: axis_out_serializer

Overview:
- Sits directly downstream of the matrix-multiply top's result master port (m_axis_*).
- Accepts wide result beats of packed Q8.8 16-bit elements.
- Splits each beat into narrower AXI-Stream beats for the DMA write channel, preserving packet framing.
- Counts completed packets for software status.

Parameters:
- IN_WIDTH, 128, width of the upstream result beat in bits; an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 64, width of the downstream beat in bits; a multiple of 16.
- CNT_WIDTH, 16, width of the packet counter.

Ports:
- aclk  input  1  clock; all logic on the rising edge.
- areset  input  1  asynchronous, active-high reset.
- s_axis_tdata  input  IN_WIDTH  wide result beat from the multiplier.
- s_axis_tvalid  input  1  upstream data valid.
- s_axis_tlast  input  1  upstream end of packet.
- s_axis_tready  output  1  serializer can take a wide beat.
- m_axis_tdata  output  OUT_WIDTH  current slice.
- m_axis_tvalid  output  1  slice valid.
- m_axis_tlast  output  1  final slice of a packet.
- m_axis_tready  input  1  downstream ready.
- pkt_count  output  CNT_WIDTH  number of packets fully emitted.
- busy  output  1  holding register occupied.

Behaviour:
- RATIO = IN_WIDTH/OUT_WIDTH; slice index width = clog2(RATIO), minimum 1.
- Storage:
  - hold_data (IN_WIDTH), hold_last (1), hold_valid (1), slice index idx.
  - A two-state FSM: EMPTY (hold_valid=0) and SEND (hold_valid=1).
- Reset (asynchronous, immediate on areset=1):
  - hold_valid=0, idx=0, pkt_count=0, hold_data=0, hold_last=0.
  - Outputs: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0 while areset is high, busy=0.
  - A beat partly emitted when reset asserts is discarded; no partial slices follow release.
- s_axis_tready:
  - Equals (!hold_valid) OR (idx==RATIO-1 AND m_axis_tready).
  - Combinational from registered state and m_axis_tready.
  - Never depends on s_axis_tvalid.
- Load: on s_axis_tvalid && s_axis_tready:
  - hold_data <= s_axis_tdata, hold_last <= s_axis_tlast, hold_valid <= 1, idx <= 0.
- Output, combinational from registers:
  - m_axis_tvalid = hold_valid.
  - m_axis_tdata = hold_data[idx*OUT_WIDTH +: OUT_WIDTH]; least-significant slice first.
  - m_axis_tlast = hold_valid && hold_last && idx==RATIO-1; non-final slices always carry tlast=0.
- Slice transfer on m_axis_tvalid && m_axis_tready:
  - idx<RATIO-1: idx <= idx+1.
  - idx==RATIO-1 with no simultaneous load: hold_valid <= 0, idx <= 0.
  - idx==RATIO-1 with simultaneous load: the load wins, hold_valid stays 1, idx <= 0. This gives zero-bubble back-to-back throughput of one slice per clock.
- Backpressure:
  - While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast are held stable and idx does not change.
  - m_axis_tvalid never drops until the slice transfers.
- pkt_count:
  - Increments by 1 on each transfer with m_axis_tlast=1.
  - Wraps modulo 2^CNT_WIDTH.
- busy = hold_valid.
- Latency: first slice valid the cycle after the wide beat is accepted. A packet of B wide beats emits B*RATIO slices.
- RATIO==1 degenerates to a one-stage register slice with the same rules.
- s_axis_tvalid asserted with tready low is ignored; upstream must hold its data.

Test Plan:
- Reset then single beat: s_axis_tdata=128'h02000100020002000100020001000100, tlast=1, m_axis_tready=1 -> next cycle m_axis_tdata=64'h0100020001000100 (tlast=0), following cycle 64'h0200010002000200 (tlast=1), then tvalid=0, pkt_count=1.
- Back-to-back 4-beat packet (tlast on beat 4), tvalid and tready held high -> 8 consecutive slices with no gaps, s_axis_tready high on every second cycle, tlast only on slice 8, pkt_count=1.
- Backpressure: m_axis_tready toggled 1,0,0,1 during slice 0 -> slice 0 data stable across stall cycles, no extra slices, s_axis_tready=0 throughout stall.
- Asynchronous reset asserted mid-packet after slice 0 of beat 2 -> outputs zero immediately without a clock edge, pkt_count=0, and a fresh packet after release starts at slice 0.
- Counter wrap with CNT_WIDTH=4: 17 single-beat packets -> pkt_count reads 1 after the 17th tlast.
- Upstream tvalid with tlast=0 for 3 beats then idle -> exactly 6 slices, none with tlast, pkt_count unchanged, busy=0 afterwards.

Source files
------------

// File: rtl/axis_out_serializer.sv
// axis_out_serializer: splits wide AXI-Stream result beats into narrower slices,
// least-significant slice first, and counts completed packets.
module axis_out_serializer #(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [IN_WIDTH-1:0]  s_axis_tdata,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tlast,
    output logic                 s_axis_tready,
    output logic [OUT_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready,
    output logic [CNT_WIDTH-1:0] pkt_count,
    output logic                 busy
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IW    = RATIO > 1 ? $clog2(RATIO) : 1;

    typedef enum logic {EMPTY, SEND} state_t;

    state_t               state_q, state_d;
    logic [IN_WIDTH-1:0]  data_q, data_d;
    logic                 last_q, last_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 hold_valid, last_idx, load, m_xfer;

    assign hold_valid    = state_q == SEND;
    assign last_idx      = idx_q == IW'(RATIO - 1);
    // Ready is forced low during reset so no beat can be taken while state is cleared.
    assign s_axis_tready = !areset && (!hold_valid || (last_idx && m_axis_tready));
    assign load          = s_axis_tvalid && s_axis_tready;
    assign m_xfer        = hold_valid && m_axis_tready;
    assign m_axis_tvalid = hold_valid;
    assign m_axis_tdata  = data_q[idx_q*OUT_WIDTH +: OUT_WIDTH];
    assign m_axis_tlast  = hold_valid && last_q && last_idx;
    assign pkt_count     = cnt_q;
    assign busy          = hold_valid;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        last_d  = last_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CNT_WIDTH'(m_xfer && m_axis_tlast);
        // A load coincident with the final slice wins, giving zero-bubble streaming.
        if (load) begin
            state_d = SEND;
            data_d  = s_axis_tdata;
            last_d  = s_axis_tlast;
            idx_d   = '0;
        end else if (m_xfer) begin
            state_d = last_idx ? EMPTY : SEND;
            idx_d   = last_idx ? '0 : idx_q + IW'(1);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= EMPTY;
            data_q  <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
